cond_branch_unit: RTL and testbench

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

---
 rtl/cbu_pkg.sv | 39 +++
 rtl/cond_eval.sv | 35 +++
 rtl/cond_branch_unit.sv | 99 +++++++++
 tb/tb_cond_branch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbu_pkg.sv
// Shared definitions for the conditional branch unit: condition codes, FSM
// states, icc bit positions and the cc-op opcode pattern.
package cbu_pkg;

  localparam int unsigned ICC_N = 3;
  localparam int unsigned ICC_Z = 2;
  localparam int unsigned ICC_C = 1;
  localparam int unsigned ICC_V = 0;
  localparam int unsigned CNT_W = 16;

  // op[5:4] value marking an instruction that writes icc
  localparam logic [1:0] CC_OP_PAT = 2'b01;

  typedef enum logic [3:0] {
    COND_BN   = 4'b0000,
    COND_BE   = 4'b0001,
    COND_BLE  = 4'b0010,
    COND_BL   = 4'b0011,
    COND_BLEU = 4'b0100,
    COND_BCS  = 4'b0101,
    COND_BNEG = 4'b0110,
    COND_BVS  = 4'b0111,
    COND_BA   = 4'b1000,
    COND_BNE  = 4'b1001,
    COND_BG   = 4'b1010,
    COND_BGE  = 4'b1011,
    COND_BGU  = 4'b1100,
    COND_BCC  = 4'b1101,
    COND_BPOS = 4'b1110,
    COND_BVC  = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ANNUL = 2'd2
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: cond[2:0] selects a base
// predicate on {N,Z,C,V}, cond[3] inverts it (0000 never / 1000 always).
module cond_eval
  import cbu_pkg::*;
(
  input  logic [3:0] icc,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n_f, z_f, c_f, v_f;
  logic base;

  assign n_f = icc[ICC_N];
  assign z_f = icc[ICC_Z];
  assign c_f = icc[ICC_C];
  assign v_f = icc[ICC_V];

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z_f;
      3'd2:    base = z_f | (n_f ^ v_f);
      3'd3:    base = n_f ^ v_f;
      3'd4:    base = c_f | z_f;
      3'd5:    base = c_f;
      3'd6:    base = n_f;
      3'd7:    base = v_f;
      default: base = 1'b0;
    endcase
    taken = base ^ cond[3];
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Integer condition-code register plus delayed-branch / annul FSM.
// Optional branch statistics counters are enabled by defining BR_STATS_EN.
module cond_branch_unit
  import cbu_pkg::*;
#(
  parameter int unsigned CC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic            alu_N,
  input  logic            alu_Z,
  input  logic            alu_C,
  input  logic            alu_V,
  input  logic            adv,
  input  logic            br_valid,
  input  logic [3:0]      cond,
  input  logic            annul_bit,
  output logic [CC_W-1:0] icc,
  output logic            ci,
  output logic            br_taken,
  output logic            annul_slot,
  output logic [1:0]      st
`ifdef BR_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
`endif
);

  logic [CC_W-1:0] icc_q;
  state_e          state_q;
  logic            br_taken_q;
  logic            taken;
  logic            accept_c;
  logic            annul_c;
  logic            icc_we_c;
  logic            unused_op;

  assign unused_op = ^op[3:0];

  // Branch uses the registered (pre-write) icc even if a cc-op retires alongside.
  cond_eval u_cond_eval (
    .icc   (icc_q[3:0]),
    .cond  (cond),
    .taken (taken)
  );

  always_comb begin
    accept_c = adv & br_valid & ((state_q == ST_IDLE) | (state_q == ST_DELAY));
    annul_c  = annul_bit & (~taken | (cond == 4'(COND_BA)));
    icc_we_c = adv & (op[5:4] == CC_OP_PAT) & (state_q != ST_ANNUL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icc_q      <= '0;
      state_q    <= ST_IDLE;
      br_taken_q <= 1'b0;
    end else begin
      if (icc_we_c) icc_q <= CC_W'({alu_N, alu_Z, alu_C, alu_V});
      br_taken_q <= accept_c & taken;
      case (state_q)
        ST_IDLE, ST_DELAY: begin
          if (accept_c)  state_q <= annul_c ? ST_ANNUL : ST_DELAY;
          else if (adv)  state_q <= ST_IDLE;
        end
        ST_ANNUL: if (adv) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] br_taken_count_q;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
    end else if (accept_c) begin
      if (br_count_q != '1) br_count_q <= br_count_q + CNT_W'(1);
      if (taken && (br_taken_count_q != '1)) br_taken_count_q <= br_taken_count_q + CNT_W'(1);
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_count_q;
`endif

  assign icc        = icc_q;
  assign ci         = icc_q[ICC_C];
  assign br_taken   = br_taken_q;
  assign annul_slot = (state_q == ST_ANNUL);
  assign st         = state_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit: directed scenarios plus random traffic
// against a behavioural model; define BR_STATS_EN to also check the counters.
module tb_cond_branch_unit;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       alu_N, alu_Z, alu_C, alu_V;
  logic       adv, br_valid, annul_bit;
  logic [3:0] cond;
  logic [3:0] icc;
  logic       ci, br_taken, annul_slot;
  logic [1:0] st;
  logic [15:0] br_count, br_taken_count;

  cond_branch_unit #(.CC_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .alu_N      (alu_N),
    .alu_Z      (alu_Z),
    .alu_C      (alu_C),
    .alu_V      (alu_V),
    .adv        (adv),
    .br_valid   (br_valid),
    .cond       (cond),
    .annul_bit  (annul_bit),
    .icc        (icc),
    .ci         (ci),
    .br_taken   (br_taken),
    .annul_slot (annul_slot),
    .st         (st)
`ifdef BR_STATS_EN
    ,
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
`endif
  );

`ifndef BR_STATS_EN
  assign br_count       = 16'h0;
  assign br_taken_count = 16'h0;
`endif

  typedef struct {
    logic [3:0]  icc;
    logic        ci;
    logic        bt;
    logic        an;
    logic [1:0]  st;
    logic [15:0] bc;
    logic [15:0] btc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model state
  int         m_state;   // 0 idle, 1 delay, 2 annul
  logic [3:0] m_icc;
  logic       m_bt;
  int         m_bc, m_btc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Branch condition truth table written straight from the condition list.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'b1000: return 1;
      4'b0000: return 0;
      4'b1001: return !z;
      4'b0001: return z;
      4'b1010: return !(z || (n != v));
      4'b0010: return z || (n != v);
      4'b1011: return n == v;
      4'b0011: return n != v;
      4'b1100: return !(cy || z);
      4'b0100: return cy || z;
      4'b1101: return !cy;
      4'b0101: return cy;
      4'b1110: return !n;
      4'b0110: return n;
      4'b1111: return !v;
      default: return v;
    endcase
  endfunction

  // Drive one cycle of inputs and enqueue what should be visible after the edge.
  task automatic cyc(input bit rst, input logic [5:0] o, input logic [3:0] fl,
                     input bit a, input bit bv, input logic [3:0] c, input bit ab);
    bit   tk, acc;
    exp_t e;
    @(negedge clk);
    reset = rst; op = o; {alu_N, alu_Z, alu_C, alu_V} = fl;
    adv = a; br_valid = bv; cond = c; annul_bit = ab;
    if (rst) begin
      m_icc = 4'h0; m_state = 0; m_bt = 0; m_bc = 0; m_btc = 0;
    end else begin
      tk  = cond_true(c, m_icc);
      acc = a && bv && (m_state != 2);
      m_bt = acc && tk;
      if (acc) begin
        if (m_bc < 65535) m_bc++;
        if (tk && m_btc < 65535) m_btc++;
      end
      if (a && o[5:4] == 2'b01 && m_state != 2) m_icc = fl;
      if (acc) m_state = (ab && (!tk || c == 4'b1000)) ? 2 : 1;
      else if (a) m_state = 0;
    end
    e.icc = m_icc; e.ci = m_icc[1]; e.bt = m_bt; e.an = (m_state == 2);
    e.st = 2'(m_state); e.bc = 16'(m_bc); e.btc = 16'(m_btc);
    exp_q.push_back(e);
  endtask

  task automatic nop(input bit a);
    cyc(0, 6'h00, 4'h0, a, 0, 4'h0, 0);
  endtask

  task automatic br(input logic [3:0] c, input bit ab);
    cyc(0, 6'h00, 4'h0, 1, 1, c, ab);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_icc", 32'(icc), 32'(e.icc));
      check("sb_ci", 32'(ci), 32'(e.ci));
      check("sb_br_taken", 32'(br_taken), 32'(e.bt));
      check("sb_annul_slot", 32'(annul_slot), 32'(e.an));
      check("sb_st", 32'(st), 32'(e.st));
`ifdef BR_STATS_EN
      check("sb_br_count", 32'(br_count), 32'(e.bc));
      check("sb_br_taken_count", 32'(br_taken_count), 32'(e.btc));
`endif
    end
  end

  initial begin
    reset = 1; op = 0; {alu_N, alu_Z, alu_C, alu_V} = 4'h0;
    adv = 0; br_valid = 0; cond = 0; annul_bit = 0;
    m_icc = 0; m_state = 0; m_bt = 0; m_bc = 0; m_btc = 0;

    cyc(1, 6'h00, 4'hF, 1, 1, 4'b1000, 1);
    cyc(1, 6'h14, 4'hF, 1, 0, 4'h0, 0);
    settle();
    check("rst_icc", 32'(icc), 32'h0);
    check("rst_st", 32'(st), 32'h0);
    check("rst_br_taken", 32'(br_taken), 32'h0);
    check("rst_annul_slot", 32'(annul_slot), 32'h0);

    // subcc sets Z, then BE taken with no annul
    cyc(0, 6'b010100, 4'b0100, 1, 0, 4'h0, 0);
    br(4'b0001, 0);
    settle();
    check("be_icc", 32'(icc), 32'h4);
    check("be_taken", 32'(br_taken), 32'h1);
    check("be_st", 32'(st), 32'h1);
    check("be_slot_live", 32'(annul_slot), 32'h0);
    nop(1);
    settle();
    check("be_pulse_end", 32'(br_taken), 32'h0);
    check("be_idle", 32'(st), 32'h0);

    // BNE,a untaken annuls the following andcc, which must not write icc
    br(4'b1001, 1);
    settle();
    check("bne_not_taken", 32'(br_taken), 32'h0);
    check("bne_annul_st", 32'(st), 32'h2);
    check("bne_annul_slot", 32'(annul_slot), 32'h1);
    cyc(0, 6'b010001, 4'b0000, 1, 0, 4'h0, 0);
    settle();
    check("andcc_squashed_icc", 32'(icc), 32'h4);
    check("annul_to_idle", 32'(st), 32'h0);

    // BA,a annuls despite being taken; BN without annul goes to DELAY
    br(4'b1000, 1);
    settle();
    check("ba_taken", 32'(br_taken), 32'h1);
    check("ba_annul", 32'(st), 32'h2);
    nop(1);
    br(4'b0000, 0);
    settle();
    check("bn_not_taken", 32'(br_taken), 32'h0);
    check("bn_delay", 32'(st), 32'h1);
    nop(1);

    // addcc overflow flags N1 Z0 C0 V1
    cyc(0, 6'b010000, 4'b1001, 1, 0, 4'h0, 0);
    br(4'b0111, 0);
    settle();
    check("bvs_taken", 32'(br_taken), 32'h1);
    check("ci_clear", 32'(ci), 32'h0);
    br(4'b0011, 0);
    settle();
    check("bl_not_taken", 32'(br_taken), 32'h0);
    br(4'b0110, 0);
    settle();
    check("bneg_taken", 32'(br_taken), 32'h1);
    nop(1);

    // Stall in ANNUL, then reset mid-annul
    br(4'b0000, 1);
    for (int i = 0; i < 3; i++) begin
      nop(0);
      settle();
      check("stall_st", 32'(st), 32'h2);
      check("stall_annul_slot", 32'(annul_slot), 32'h1);
    end
    cyc(1, 6'h00, 4'h0, 0, 0, 4'h0, 0);
    settle();
    check("rst_mid_annul_st", 32'(st), 32'h0);
    check("rst_mid_annul_slot", 32'(annul_slot), 32'h0);

`ifdef BR_STATS_EN
    br(4'b1000, 0);
    br(4'b0000, 0);
    br(4'b1000, 0);
    settle();
    check("stats_br_count", 32'(br_count), 32'd3);
    check("stats_taken_count", 32'(br_taken_count), 32'd2);
    for (int i = 0; i < 65540; i++) br(4'b1000, 0);
    settle();
    check("stats_br_sat", 32'(br_count), 32'hFFFF);
    check("stats_taken_sat", 32'(br_taken_count), 32'hFFFF);
    br(4'b1000, 0);
    settle();
    check("stats_br_hold", 32'(br_count), 32'hFFFF);
    check("stats_taken_hold", 32'(br_taken_count), 32'hFFFF);
    cyc(1, 6'h00, 4'h0, 0, 0, 4'h0, 0);
`endif

    // Random traffic; cc-ops and branches are biased to be frequent
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] o;
      o = 6'($urandom);
      if ($urandom_range(0, 2) == 0) o[5:4] = 2'b01;
      cyc(($urandom_range(0, 99) == 0), o, 4'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          4'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
